// File: rtl/pong_io_pkg.sv
// Shared constants, types and helpers for the Pong memory-mapped I/O bridge.
// Imported by the bridge, its PS2 key tracker and the bus interface users.
package pong_io_pkg;

    localparam logic [2:0] OFS_BALL_X = 3'd0;
    localparam logic [2:0] OFS_BALL_Y = 3'd1;
    localparam logic [2:0] OFS_PAD_L  = 3'd2;
    localparam logic [2:0] OFS_PAD_R  = 3'd3;
    localparam logic [2:0] OFS_COMMIT = 3'd4;
    localparam logic [2:0] OFS_KEYS   = 3'd5;
    localparam logic [2:0] OFS_TICK   = 3'd6;
    localparam logic [2:0] OFS_LAST   = 3'd7;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [9:0] RST_BALL_X = 10'd320;
    localparam logic [8:0] RST_BALL_Y = 9'd240;
    localparam logic [8:0] RST_PAD    = 9'd240;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_state_e;

    // Signed saturation of a processor store into a coordinate range [0, lim].
    function automatic logic [9:0] clamp_coord(input logic [31:0] v, input logic [9:0] lim);
        logic [9:0] res;
        if (v[31]) begin
            res = 10'd0;
        end else if (v > {22'd0, lim}) begin
            res = lim;
        end else begin
            res = v[9:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/pong_io_if.sv
// Processor data-memory side of the Pong I/O bridge: address, store and
// registered read-back with its select flag.
interface pong_io_if;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wren;
    logic [31:0] io_rdata;
    logic        io_rsel;

    modport master (
        output addr,
        output wdata,
        output wren,
        input  io_rdata,
        input  io_rsel
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wren,
        output io_rdata,
        output io_rsel
    );
endinterface

// File: rtl/pong_io_bridge_ps2_key_tracker.sv
// Turns the PS2 byte stream into held-key flags (W, S, Up, Down) and keeps
// the most recent byte. One byte event per rising edge of key_pressed.
module ps2_key_tracker
    import pong_io_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_pressed,
    input  logic [7:0] key_data,
    output logic [3:0] keys,
    output logic [7:0] last_byte
);

    logic       pressed_d_r;
    logic       byte_evt_r;
    logic [7:0] byte_data_r;
    logic [3:0] keys_r;
    logic [7:0] last_r;
    ps2_state_e state_r;

    // Rising-edge detect of the byte-valid line, with the byte captured alongside.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pressed_d_r <= 1'b0;
            byte_evt_r  <= 1'b0;
            byte_data_r <= 8'd0;
        end else begin
            pressed_d_r <= key_pressed;
            byte_evt_r  <= key_pressed & ~pressed_d_r;
            byte_data_r <= key_data;
        end
    end

    // Make/break decode FSM; keys bits: 0 W, 1 S, 2 Up, 3 Down.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            keys_r  <= 4'd0;
            last_r  <= 8'd0;
        end else if (byte_evt_r) begin
            last_r <= byte_data_r;
            case (state_r)
                IDLE: begin
                    if (byte_data_r == SC_BREAK) begin
                        state_r <= BRK;
                    end else if (byte_data_r == SC_EXT) begin
                        state_r <= EXT;
                    end else if (byte_data_r == SC_W) begin
                        keys_r[0] <= 1'b1;
                    end else if (byte_data_r == SC_S) begin
                        keys_r[1] <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BRK: begin
                    if (byte_data_r == SC_W) begin
                        keys_r[0] <= 1'b0;
                    end else if (byte_data_r == SC_S) begin
                        keys_r[1] <= 1'b0;
                    end else begin
                        keys_r <= keys_r;
                    end
                    state_r <= IDLE;
                end
                EXT: begin
                    if (byte_data_r == SC_BREAK) begin
                        state_r <= EXT_BRK;
                    end else if (byte_data_r == SC_UP) begin
                        keys_r[2] <= 1'b1;
                        state_r   <= IDLE;
                    end else if (byte_data_r == SC_DOWN) begin
                        keys_r[3] <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXT_BRK: begin
                    if (byte_data_r == SC_UP) begin
                        keys_r[2] <= 1'b0;
                    end else if (byte_data_r == SC_DOWN) begin
                        keys_r[3] <= 1'b0;
                    end else begin
                        keys_r <= keys_r;
                    end
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign keys      = keys_r;
    assign last_byte = last_r;

endmodule

// File: rtl/pong_io_bridge.sv
// Memory-mapped I/O bridge for Pong: double-buffered ball/paddle coordinates,
// PS2 key state, a fixed-rate game tick and a 1-cycle-latency read port.
module pong_io_bridge
    import pong_io_pkg::*;
#(
    parameter logic [11:0] IO_BASE  = 12'd3000,
    parameter int unsigned TICK_DIV = 166667,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MAX    = 479
) (
    input  logic        clock,
    input  logic        resetn,
    pong_io_if.slave    bus,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_key_data,
    output logic [9:0]  ball_x,
    output logic [8:0]  ball_y,
    output logic [8:0]  paddle_left,
    output logic [8:0]  paddle_right
);

    localparam logic [9:0]  X_LIM     = 10'(X_MAX);
    localparam logic [9:0]  Y_LIM     = 10'(Y_MAX);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    logic        hit_s;
    logic        wr_s;
    logic [2:0]  ofs_s;
    logic        wrap_s;
    logic        tick_clr_s;
    logic [31:0] rd_mux_s;
    logic [9:0]  clamp_x_s;
    logic [9:0]  clamp_y_s;
    logic [3:0]  keys_s;
    logic [7:0]  last_byte_s;

    logic [9:0]  sh_x_r;
    logic [8:0]  sh_y_r;
    logic [8:0]  sh_pl_r;
    logic [8:0]  sh_pr_r;
    logic [9:0]  ball_x_r;
    logic [8:0]  ball_y_r;
    logic [8:0]  pad_l_r;
    logic [8:0]  pad_r_r;
    logic [31:0] tick_cnt_r;
    logic        pending_r;
    logic [7:0]  missed_r;
    logic [31:0] io_rdata_r;
    logic        io_rsel_r;

    ps2_key_tracker u_keys (
        .clock       (clock),
        .resetn      (resetn),
        .key_pressed (ps2_key_pressed),
        .key_data    (ps2_key_data),
        .keys        (keys_s),
        .last_byte   (last_byte_s)
    );

    // Window decode and write-side qualifiers.
    always_comb begin
        hit_s      = (bus.addr >= IO_BASE) && (bus.addr <= (IO_BASE + 12'd7));
        ofs_s      = 3'(bus.addr - IO_BASE);
        wr_s       = hit_s & bus.wren;
        wrap_s     = (tick_cnt_r == TICK_LAST);
        tick_clr_s = wr_s && (ofs_s == OFS_TICK) && bus.wdata[0];
        clamp_x_s  = clamp_coord(bus.wdata, X_LIM);
        clamp_y_s  = clamp_coord(bus.wdata, Y_LIM);
    end

    // Shadow registers and commit; a commit copies the pre-edge shadow values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sh_x_r   <= RST_BALL_X;
            sh_y_r   <= RST_BALL_Y;
            sh_pl_r  <= RST_PAD;
            sh_pr_r  <= RST_PAD;
            ball_x_r <= RST_BALL_X;
            ball_y_r <= RST_BALL_Y;
            pad_l_r  <= RST_PAD;
            pad_r_r  <= RST_PAD;
        end else if (wr_s) begin
            case (ofs_s)
                OFS_BALL_X: sh_x_r  <= clamp_x_s;
                OFS_BALL_Y: sh_y_r  <= clamp_y_s[8:0];
                OFS_PAD_L:  sh_pl_r <= clamp_y_s[8:0];
                OFS_PAD_R:  sh_pr_r <= clamp_y_s[8:0];
                OFS_COMMIT: begin
                    ball_x_r <= sh_x_r;
                    ball_y_r <= sh_y_r;
                    pad_l_r  <= sh_pl_r;
                    pad_r_r  <= sh_pr_r;
                end
                default: sh_x_r <= sh_x_r;
            endcase
        end else begin
            sh_x_r <= sh_x_r;
        end
    end

    // Game tick divider with pending flag and saturating missed-tick count.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_r <= 32'd0;
            pending_r  <= 1'b0;
            missed_r   <= 8'd0;
        end else begin
            tick_cnt_r <= wrap_s ? 32'd0 : (tick_cnt_r + 32'd1);
            if (wrap_s && tick_clr_s) begin
                pending_r <= 1'b1;
                missed_r  <= 8'd0;
            end else if (wrap_s) begin
                pending_r <= 1'b1;
                if (pending_r && (missed_r != 8'd255)) begin
                    missed_r <= missed_r + 8'd1;
                end else begin
                    missed_r <= missed_r;
                end
            end else if (tick_clr_s) begin
                pending_r <= 1'b0;
                missed_r  <= 8'd0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Read mux; COMMIT reads as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (ofs_s)
            OFS_BALL_X: rd_mux_s = {22'd0, sh_x_r};
            OFS_BALL_Y: rd_mux_s = {23'd0, sh_y_r};
            OFS_PAD_L:  rd_mux_s = {23'd0, sh_pl_r};
            OFS_PAD_R:  rd_mux_s = {23'd0, sh_pr_r};
            OFS_KEYS:   rd_mux_s = {28'd0, keys_s};
            OFS_TICK:   rd_mux_s = {16'd0, missed_r, 7'd0, pending_r};
            OFS_LAST:   rd_mux_s = {24'd0, last_byte_s};
            default:    rd_mux_s = 32'd0;
        endcase
    end

    // Read port registered every cycle to match dmem latency.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            io_rsel_r  <= 1'b0;
            io_rdata_r <= 32'd0;
        end else if (hit_s) begin
            io_rsel_r  <= 1'b1;
            io_rdata_r <= rd_mux_s;
        end else begin
            io_rsel_r  <= 1'b0;
            io_rdata_r <= 32'd0;
        end
    end

    assign bus.io_rdata  = io_rdata_r;
    assign bus.io_rsel   = io_rsel_r;
    assign ball_x        = ball_x_r;
    assign ball_y        = ball_y_r;
    assign paddle_left   = pad_l_r;
    assign paddle_right  = pad_r_r;

endmodule
